// File: rtl/dmem_access_ctrl_if.sv
// Signal bundle between the CPU-side requester, dmem_access_ctrl and the word-wide data memory.
// The slave modport is the controller; the master modport is the requester/memory side.
interface dmem_access_ctrl_if #(
   parameter int addresswidth = 32
) ();

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [1:0]              req_size;
   logic                    req_signed;
   logic [31:0]             req_addr;
   logic [31:0]             req_wdata;
   logic                    resp_valid;
   logic [31:0]             resp_rdata;
   logic                    resp_error;
   logic [addresswidth-1:0] mem_address;
   logic                    mem_write_en;
   logic                    mem_read_en;
   logic [31:0]             mem_data_in;
   logic [31:0]             mem_data_out;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_en, mem_read_en, mem_data_in
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_write_en, mem_read_en, mem_data_in
   );

endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one byte-addressed load/store at a time over a word-only,
// synchronous-read memory, with sub-word extraction, read-modify-write and misalignment errors.
module dmem_access_ctrl #(
   parameter int addresswidth = 32
) (
   input logic              clk,
   input logic              rst_n,
   dmem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_CAP,
      WR,
      RMW_RD,
      RMW_WR,
      RESP
   } state_t;

   state_t      state;
   logic        write_q;
   logic        signed_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q;
   logic        resp_error_q;
   logic [31:0] resp_rdata_q;

   logic        req_illegal;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_value;
   logic [31:0] merged_word;

   always_comb begin
      req_illegal = 1'b0;
      case (bus.req_size)
         2'b00:   req_illegal = 1'b0;
         2'b01:   req_illegal = bus.req_addr[0];
         2'b10:   req_illegal = |bus.req_addr[1:0];
         default: req_illegal = 1'b1;
      endcase
   end

   // Little-endian lane pick from the registered read data, then sign/zero extension.
   always_comb begin
      byte_lane  = bus.mem_data_out[{addr_q[1:0], 3'b000} +: 8];
      half_lane  = bus.mem_data_out[{addr_q[1], 4'b0000} +: 16];
      load_value = bus.mem_data_out;
      case (size_q)
         2'b00:   load_value = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h000000, byte_lane};
         2'b01:   load_value = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'h0000, half_lane};
         default: load_value = bus.mem_data_out;
      endcase
   end

   always_comb begin
      merged_word = bus.mem_data_out;
      if (size_q == 2'b00) begin
         merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   always_comb begin
      bus.mem_data_in = 32'h0000_0000;
      if (state == WR) begin
         bus.mem_data_in = wdata_q;
      end else if (state == RMW_WR) begin
         bus.mem_data_in = merged_word;
      end
   end

   assign bus.req_ready    = (state == IDLE);
   assign bus.mem_read_en  = (state == RD) || (state == RMW_RD);
   assign bus.mem_write_en = (state == WR) || (state == RMW_WR);
   assign bus.mem_address  = addresswidth'({2'b00, addr_q[31:2]});
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_rdata   = resp_rdata_q;
   assign bus.resp_error   = resp_error_q;

   // resp_valid is set on the edge that enters RESP, so it is high for exactly the RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         size_q       <= 2'b00;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
      end else begin
         resp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  write_q  <= bus.req_write;
                  signed_q <= bus.req_signed;
                  size_q   <= bus.req_size;
                  addr_q   <= bus.req_addr;
                  wdata_q  <= bus.req_wdata;
                  if (req_illegal) begin
                     resp_valid_q <= 1'b1;
                     resp_error_q <= 1'b1;
                     resp_rdata_q <= 32'h0000_0000;
                     state        <= RESP;
                  end else if (!bus.req_write) begin
                     state <= RD;
                  end else if (bus.req_size == 2'b10) begin
                     state <= WR;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            RD:     state <= RD_CAP;
            RD_CAP: begin
               resp_valid_q <= 1'b1;
               resp_error_q <= 1'b0;
               resp_rdata_q <= load_value;
               state        <= RESP;
            end
            WR, RMW_WR: begin
               resp_valid_q <= 1'b1;
               resp_error_q <= 1'b0;
               resp_rdata_q <= 32'h0000_0000;
               state        <= RESP;
            end
            RMW_RD:  state <= RMW_WR;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a word memory model, a request-level reference
// model that schedules expected per-cycle outputs, and one negedge compare process.
module tb_dmem_access_ctrl;

   logic clk;
   logic rst_n;

   dmem_access_ctrl_if #(.addresswidth(32)) bus ();

   dmem_access_ctrl #(.addresswidth(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-only synchronous-read memory; read data is presented the cycle after read_en.
   logic [31:0] mem [0:63];
   logic [31:0] mem_rd_data;
   logic        mem_rd_valid;

   always @(posedge clk) begin
      mem_rd_valid <= bus.mem_read_en;
      if (bus.mem_read_en) mem_rd_data <= mem[bus.mem_address[5:0]];
      if (bus.mem_write_en) mem[bus.mem_address[5:0]] <= bus.mem_data_in;
   end

   assign bus.mem_data_out = mem_rd_valid ? mem_rd_data : 32'h0000_0000;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        rv;
      logic        err;
      logic        check_addr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        commit;
      logic [31:0] commit_word;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] ref_mem [0:63];
   logic [31:0] hold_rdata;
   logic        hold_err;
   int          vectors;
   int          miscompares;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
      longint unsigned v;
      int              bits;
      bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
      v = longint'(word >> (8 * off)) & ((64'd1 << bits) - 64'd1);
      if (sgn && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic [31:0] wdata);
      logic [31:0] mask;
      int          shift;
      mask  = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      shift = 8 * off;
      return (word & ~(mask << shift)) | ((wdata & mask) << shift);
   endfunction

   // Compare process: one scheduled expectation per cycle after accept, idle rules otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_rdata = 32'h0;
         hold_err   = 1'b0;
         checkOutput("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
         checkOutput("rst_resp_error", {31'b0, bus.resp_error}, 32'd0);
         checkOutput("rst_resp_rdata", bus.resp_rdata, 32'd0);
         checkOutput("rst_read_en", {31'b0, bus.mem_read_en}, 32'd0);
         checkOutput("rst_write_en", {31'b0, bus.mem_write_en}, 32'd0);
         checkOutput("rst_mem_address", bus.mem_address, 32'd0);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("read_en", {31'b0, bus.mem_read_en}, {31'b0, e.rd});
         checkOutput("write_en", {31'b0, bus.mem_write_en}, {31'b0, e.wr});
         checkOutput("resp_valid", {31'b0, bus.resp_valid}, {31'b0, e.rv});
         checkOutput("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
         if (e.check_addr) checkOutput("mem_address", bus.mem_address, e.addr);
         if (e.wr) checkOutput("mem_data_in", bus.mem_data_in, e.wdata);
         if (e.rv) begin
            checkOutput("resp_rdata", bus.resp_rdata, e.rdata);
            checkOutput("resp_error", {31'b0, bus.resp_error}, {31'b0, e.err});
            hold_rdata = e.rdata;
            hold_err   = e.err;
            if (e.commit) ref_mem[e.addr[5:0]] = e.commit_word;
         end
      end else begin
         checkOutput("idle_read_en", {31'b0, bus.mem_read_en}, 32'd0);
         checkOutput("idle_write_en", {31'b0, bus.mem_write_en}, 32'd0);
         checkOutput("idle_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
         checkOutput("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
         checkOutput("hold_resp_rdata", bus.resp_rdata, hold_rdata);
         checkOutput("hold_resp_error", {31'b0, bus.resp_error}, {31'b0, hold_err});
      end
   end

   // Drive one request, let it be accepted, then schedule what every following cycle must show.
   task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
      exp_t        e;
      exp_t        sched [$];
      logic [31:0] word;
      logic [31:0] widx;
      bit          illegal;
      illegal = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
      widx    = addr >> 2;
      word    = ref_mem[addr[7:2]];
      e = '{default: '0};
      e.check_addr = 1'b1;
      e.addr       = widx;
      if (illegal) begin
         e.check_addr = 1'b0;
         e.rv = 1'b1; e.err = 1'b1; e.rdata = 32'h0;
         sched.push_back(e);
      end else if (!wr) begin
         e.rd = 1'b1;                               sched.push_back(e);
         e.rd = 1'b0;                               sched.push_back(e);
         e.rv = 1'b1; e.rdata = model_load(word, size, sgn, addr[1:0]);
         sched.push_back(e);
      end else if (size == 2'd2) begin
         e.wr = 1'b1; e.wdata = wdata;              sched.push_back(e);
         e.wr = 1'b0; e.rv = 1'b1; e.commit = 1'b1; e.commit_word = wdata;
         sched.push_back(e);
      end else begin
         e.rd = 1'b1;                               sched.push_back(e);
         e.rd = 1'b0; e.wr = 1'b1; e.wdata = model_merge(word, size, addr[1:0], wdata);
         sched.push_back(e);
         e.commit_word = e.wdata;
         e.wr = 1'b0; e.rv = 1'b1; e.commit = 1'b1;
         sched.push_back(e);
      end
      @(negedge clk);
      checkOutput("req_ready_accept", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      foreach (sched[i]) exp_q.push_back(sched[i]);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("response_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      applyStimulus(wr, size, sgn, addr, wdata);
      wait_done();
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      hold_rdata     = 32'h0;
      hold_err       = 1'b0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Word store then load back at byte address 0x40 (word index 0x10).
      do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      checkOutput("lw_0x40", bus.resp_rdata, 32'hDEADBEEF);

      // Byte and halfword loads from 0x80F17F02 at 0x20.
      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80F17F02);
      do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
      checkOutput("lb_0x23", bus.resp_rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
      checkOutput("lbu_0x23", bus.resp_rdata, 32'h00000080);
      do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
      checkOutput("lb_0x21", bus.resp_rdata, 32'h0000007F);
      do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
      checkOutput("lh_0x22", bus.resp_rdata, 32'hFFFF80F1);
      do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
      checkOutput("lhu_0x20", bus.resp_rdata, 32'h00007F02);

      // Sub-word read-modify-write stores on 0x11223344 at 0x8.
      do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344);
      do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'hFFFF_FFAB);
      checkOutput("sb_resp_rdata", bus.resp_rdata, 32'h0);
      do_req(1'b1, 2'd1, 1'b0, 32'hA, 32'h1234_CDEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
      checkOutput("rmw_word_0x8", bus.resp_rdata, 32'hCDEFAB44);

      // Misaligned / illegal requests after a nonzero load result.
      do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
      checkOutput("lw_0x6_error", {31'b0, bus.resp_error}, 32'd1);
      do_req(1'b1, 2'd1, 1'b0, 32'h5, 32'hBEEF);
      do_req(1'b0, 2'd3, 1'b1, 32'h0, 32'h0);
      checkOutput("size11_rdata", bus.resp_rdata, 32'h0);

      // Reset during the read half of a byte store must leave memory untouched.
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hA5A55A5A);
      applyStimulus(1'b1, 2'd0, 1'b0, 32'h10, 32'h0000_003C);
      @(negedge clk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #2;
      checkOutput("mid_rst_ready", {31'b0, bus.req_ready}, 32'd1);
      checkOutput("mid_rst_write_en", {31'b0, bus.mem_write_en}, 32'd0);
      #8 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checkOutput("lw_after_rst", bus.resp_rdata, 32'hA5A55A5A);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running, want finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller for the word-wide, synchronous-read data memory.
- Accepts one byte-addressed load/store at a time from the CPU datapath and drives the memory's address/write_en/read_en/data_in.
- Captures the memory's registered read data one cycle after read_en.
- Memory is word-only, so the block does byte/halfword extraction with sign/zero extension, read-modify-write for sub-word stores, and misalignment detection.

Parameters:
- addresswidth, 32, width of mem_address (word index into data memory).
- Data width is fixed at 32; no parameter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid; misaligned or illegal size.
- mem_address  out  addresswidth  word index = req_addr[31:2], zero-extended.
- mem_write_en  out  1  to memory write_en.
- mem_read_en  out  1  to memory read_en.
- mem_data_in  out  32  to memory data_in.
- mem_data_out  in  32  from memory data_out; valid the cycle after mem_read_en; high-Z otherwise.

Behaviour:
- Reset (async, rst_n low) gives:
  - state=IDLE; resp_valid=0, resp_error=0, resp_rdata=0.
  - mem_read_en=0, mem_write_en=0; latched request and mem_address=0.
  - Reset mid-operation abandons the access. No memory enable is asserted after reset; a partial RMW never writes.
- Accept on posedge when req_valid && req_ready: latch write, size, signed, addr, wdata.
- Error check at accept: illegal if size=11, half with addr[0]=1, or word with addr[1:0]!=00. Illegal requests go to RESP with error=1 and no memory access.
- Byte lanes are little-endian:
  - byte k (k=addr[1:0]) is bits [8k+7:8k];
  - half at addr[1] is bits [16*addr[1]+15:16*addr[1]].
- FSM states: IDLE, RD, RD_CAP, WR, RMW_RD, RMW_WR, RESP.
- Transitions from IDLE on accept:
  - legal load -> RD
  - word store -> WR
  - byte/half store -> RMW_RD
  - illegal -> RESP
- RD: mem_read_en=1 -> RD_CAP.
- RD_CAP: mem_data_out valid. Extract lane, extend per req_signed, register into resp_rdata -> RESP.
- WR: mem_write_en=1, mem_data_in=wdata -> RESP.
- RMW_RD: mem_read_en=1 -> RMW_WR.
- RMW_WR: mem_write_en=1; mem_data_in = mem_data_out with the selected lane replaced by wdata low byte/half (combinational merge) -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_rdata/resp_error hold until the next RESP.
- mem_read_en and mem_write_en are combinational from state, never both 1, and both 0 in IDLE/RESP.
- mem_address is stable from the cycle after accept through RESP.
- Latency from accept edge to resp_valid:
  - load: 3 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- No response backpressure. req_ready is low in every non-IDLE state, so back-to-back requests are accepted the cycle after RESP.
- resp_rdata is cleared to 0 when a store or error enters RESP.

Test Plan:
- Reset mid-RMW:
  - stimulus: sb to 0x10 accepted, rst_n pulsed low during RMW_RD;
  - required: no mem_write_en pulse, state returns to IDLE, and a subsequent lw 0x10 returns the original word.
- Word store then load:
  - stimulus: sw 0xDEADBEEF @0x40, then lw @0x40;
  - required: mem_address=0x10 on both; write_en 1 cycle; load resp_rdata=0xDEADBEEF 3 cycles after accept.
- Byte loads from word 0x80F17F02 @0x20:
  - lb @0x23 -> 0xFFFFFF80
  - lbu @0x23 -> 0x00000080
  - lb @0x21 -> 0x0000007F
- Half loads from the same word:
  - lh @0x22 -> 0xFFFF80F1
  - lhu @0x20 -> 0x00007F02
- Sub-word RMW stores on word 0x11223344 @0x8:
  - stimulus: sb 0xAB @0x9, then sh 0xCDEF @0xA;
  - required: memory word becomes 0xCDEFAB44; each store shows read_en then write_en in consecutive cycles.
- Misaligned requests:
  - stimulus: lw @0x6, sh @0x5, size=11;
  - required: resp_valid one cycle after accept with resp_error=1, resp_rdata=0, and no read_en/write_en asserted.
